// File: rtl/param_math_accel_pkg.sv
// Shared constants for param_math_accel: opcodes, register map, CSR bit
// positions and the control FSM state encoding.
package param_math_accel_pkg;

  // Opcodes held in the OP register
  localparam logic [3:0] OP_ADD = 4'd0;
  localparam logic [3:0] OP_SUB = 4'd1;
  localparam logic [3:0] OP_MUL = 4'd2;
  localparam logic [3:0] OP_DIV = 4'd3;
  localparam logic [3:0] OP_AND = 4'd4;
  localparam logic [3:0] OP_OR  = 4'd5;
  localparam logic [3:0] OP_XOR = 4'd6;
  localparam logic [3:0] OP_MIN = 4'd7;
  localparam logic [3:0] OP_MAX = 4'd8;
  localparam logic [3:0] OP_SHL = 4'd9;

  // Register addresses
  localparam logic [3:0] ADDR_A0    = 4'h0;
  localparam logic [3:0] ADDR_B0    = 4'h4;
  localparam logic [3:0] ADDR_OP    = 4'h8;
  localparam logic [3:0] ADDR_CSR   = 4'h9;
  localparam logic [3:0] ADDR_RSEL  = 4'hA;
  localparam logic [3:0] ADDR_RDATA = 4'hB;

  // CSR read bits
  localparam int unsigned CSR_BUSY    = 0;
  localparam int unsigned CSR_DONE    = 1;
  localparam int unsigned CSR_DZ      = 2;
  localparam int unsigned CSR_ILLEGAL = 3;
  localparam int unsigned CSR_CARRY   = 4;

  // CSR write command bits
  localparam int unsigned CMD_START = 0;
  localparam int unsigned CMD_CLEAR = 1;
  localparam int unsigned CMD_ABORT = 2;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } state_e;

endpackage

// File: rtl/seq_muldiv_unit.sv
// Iterative unsigned multiply (shift-add) / divide (restoring), W steps.
// Ports: clk, rst_n; start loads a/b and is_div; abort cancels; busy while
// stepping; done pulses for one cycle after the last step; result is
// {hi, lo} = product, or {remainder, quotient} for divide.
module seq_muldiv_unit
  import param_math_accel_pkg::*;
#(
  parameter int unsigned W = 16
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           start,
  input  logic           is_div,
  input  logic [W-1:0]   a,
  input  logic [W-1:0]   b,
  input  logic           abort,
  output logic           busy,
  output logic           done,
  output logic [2*W-1:0] result
);

  localparam int unsigned CW = $clog2(W);

  logic          busy_q, busy_d;
  logic          done_q, done_d;
  logic          div_q, div_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [W-1:0]  hi_q, hi_d;
  logic [W-1:0]  lo_q, lo_d;
  logic [W-1:0]  opnd_q, opnd_d;
  logic [W:0]    mul_sum;
  logic [W:0]    div_shift;

  // Datapath step and sequencing
  always_comb begin
    busy_d = busy_q;
    done_d = 1'b0;
    div_d  = div_q;
    cnt_d  = cnt_q;
    hi_d   = hi_q;
    lo_d   = lo_q;
    opnd_d = opnd_q;

    // Multiply: conditionally add multiplicand to the high half, then shift
    // the whole {sum, lo} pair right; lo holds the remaining multiplier bits.
    mul_sum   = {1'b0, hi_q} + (lo_q[0] ? {1'b0, opnd_q} : '0);
    // Divide: shift next dividend bit into the partial remainder.
    div_shift = {hi_q, lo_q[W-1]};

    if (abort) begin
      busy_d = 1'b0;
    end else if (start) begin
      busy_d = 1'b1;
      cnt_d  = '0;
      div_d  = is_div;
      hi_d   = '0;
      lo_d   = a;
      opnd_d = b;
    end else if (busy_q) begin
      if (div_q) begin
        if (div_shift >= {1'b0, opnd_q}) begin
          hi_d = W'(div_shift - {1'b0, opnd_q});
          lo_d = {lo_q[W-2:0], 1'b1};
        end else begin
          hi_d = div_shift[W-1:0];
          lo_d = {lo_q[W-2:0], 1'b0};
        end
      end else begin
        hi_d = mul_sum[W:1];
        lo_d = {mul_sum[0], lo_q[W-1:1]};
      end
      cnt_d = cnt_q + CW'(1);
      if (cnt_q == CW'(W - 1)) begin
        busy_d = 1'b0;
        done_d = 1'b1;
      end
    end
  end

  // State registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      busy_q <= 1'b0;
      done_q <= 1'b0;
      div_q  <= 1'b0;
      cnt_q  <= '0;
      hi_q   <= '0;
      lo_q   <= '0;
      opnd_q <= '0;
    end else begin
      busy_q <= busy_d;
      done_q <= done_d;
      div_q  <= div_d;
      cnt_q  <= cnt_d;
      hi_q   <= hi_d;
      lo_q   <= lo_d;
      opnd_q <= opnd_d;
    end
  end

  assign busy   = busy_q;
  assign done   = done_q;
  assign result = {hi_q, lo_q};

endmodule

// File: rtl/param_math_accel.sv
// Memory-mapped math accelerator on the TinyQV 8-bit peripheral bus.
// Ports: clk, rst_n; ui_in (unused); uo_out (bit1 busy, bit2 done when
// IRQ_OUT); address/data_write/data_in bus write; data_out combinational
// read of the current address.
module param_math_accel
  import param_math_accel_pkg::*;
#(
  parameter int unsigned W       = 16,
  parameter bit          IRQ_OUT = 1'b1
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] ui_in,
  output logic [7:0] uo_out,
  input  logic [3:0] address,
  input  logic       data_write,
  input  logic [7:0] data_in,
  output logic [7:0] data_out
);

  localparam int unsigned NB = W / 8;
  localparam int unsigned RW = 2 * W;
  localparam int unsigned SW = $clog2(W);

  logic [W-1:0]  a_q, a_d, b_q, b_d;
  logic [3:0]    op_q, op_d;
  logic [2:0]    rsel_q, rsel_d;
  state_e        state_q, state_d;
  logic          pend_q, pend_d;
  logic          done_q, done_d;
  logic          dz_q, dz_d;
  logic          ill_q, ill_d;
  logic          carry_q, carry_d;
  logic [RW-1:0] result_q, result_d;
  logic [7:0]    uo_out_q, uo_out_d;

  logic          wr_csr, cmd_start, cmd_clear, cmd_abort;
  logic          accept, kill, is_multi;
  logic          mu_busy, mu_done;
  logic [RW-1:0] mu_result;

  logic [RW-1:0] alu_res;
  logic          alu_carry, alu_ill, alu_dz;
  logic [W:0]    sum, diff;
  logic [31:0]   a_w, b_w;

  logic          unused_ui;
  assign unused_ui = &{1'b0, ui_in};

  // Command decode; START only accepted when nothing is pending or running
  always_comb begin
    wr_csr    = data_write && (address == ADDR_CSR);
    cmd_start = wr_csr && data_in[CMD_START];
    cmd_clear = wr_csr && data_in[CMD_CLEAR];
    cmd_abort = wr_csr && data_in[CMD_ABORT];
    is_multi  = (op_q == OP_MUL) || ((op_q == OP_DIV) && (b_q != '0));
    accept    = cmd_start && (state_q == ST_IDLE) && !pend_q && !mu_busy;
    kill      = cmd_abort && ((state_q == ST_RUN) || mu_busy);
  end

  seq_muldiv_unit #(.W(W)) u_muldiv (
    .clk    (clk),
    .rst_n  (rst_n),
    .start  (accept && is_multi),
    .is_div (op_q == OP_DIV),
    .a      (a_q),
    .b      (b_q),
    .abort  (kill),
    .busy   (mu_busy),
    .done   (mu_done),
    .result (mu_result)
  );

  // Single-cycle ALU. It is evaluated one cycle after START is accepted;
  // A/B/OP cannot have changed in between because the START write itself
  // occupied the bus on the accepting edge.
  always_comb begin
    alu_res   = '0;
    alu_carry = 1'b0;
    alu_ill   = 1'b0;
    alu_dz    = 1'b0;
    sum       = {1'b0, a_q} + {1'b0, b_q};
    diff      = {1'b0, a_q} - {1'b0, b_q};
    case (op_q)
      OP_ADD: begin
        alu_res   = RW'(sum);
        alu_carry = sum[W];
      end
      OP_SUB: begin
        alu_res   = RW'(diff[W-1:0]);
        alu_carry = diff[W];
      end
      OP_MUL: alu_res = '0;
      OP_DIV: begin
        alu_res = {a_q, {W{1'b1}}};
        alu_dz  = 1'b1;
      end
      OP_AND: alu_res = RW'(a_q & b_q);
      OP_OR:  alu_res = RW'(a_q | b_q);
      OP_XOR: alu_res = RW'(a_q ^ b_q);
      OP_MIN: alu_res = RW'((a_q < b_q) ? a_q : b_q);
      OP_MAX: alu_res = RW'((a_q < b_q) ? b_q : a_q);
      OP_SHL: alu_res = RW'(a_q) << b_q[SW-1:0];
      default: alu_ill = 1'b1;
    endcase
  end

  // Register writes and control FSM
  always_comb begin
    a_d      = a_q;
    b_d      = b_q;
    op_d     = op_q;
    rsel_d   = rsel_q;
    state_d  = state_q;
    pend_d   = 1'b0;
    done_d   = done_q;
    dz_d     = dz_q;
    ill_d    = ill_q;
    carry_d  = carry_q;
    result_d = result_q;
    a_w      = 32'(a_q);
    b_w      = 32'(b_q);

    // Operand bytes beyond the configured width are dropped by truncation
    if (data_write && (address[3:2] == 2'b00) && (32'(address[1:0]) < NB))
      a_w[{address[1:0], 3'b000} +: 8] = data_in;
    if (data_write && (address[3:2] == 2'b01) && (32'(address[1:0]) < NB))
      b_w[{address[1:0], 3'b000} +: 8] = data_in;
    a_d = a_w[W-1:0];
    b_d = b_w[W-1:0];
    if (data_write && (address == ADDR_OP))   op_d   = data_in[3:0];
    if (data_write && (address == ADDR_RSEL)) rsel_d = data_in[2:0];

    case (state_q)
      ST_IDLE: begin
        if (pend_q) begin
          if (mu_busy) begin
            if (!kill) state_d = ST_RUN;
          end else begin
            result_d = alu_res;
            carry_d  = alu_carry;
            ill_d    = alu_ill;
            dz_d     = alu_dz;
            done_d   = 1'b1;
          end
        end
      end
      ST_RUN: begin
        if (kill) begin
          state_d = ST_IDLE;
        end else if (mu_done) begin
          result_d = mu_result;
          done_d   = 1'b1;
          state_d  = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    if (cmd_clear) begin
      done_d  = 1'b0;
      dz_d    = 1'b0;
      ill_d   = 1'b0;
      carry_d = 1'b0;
    end

    if (accept) begin
      done_d  = 1'b0;
      dz_d    = 1'b0;
      ill_d   = 1'b0;
      carry_d = 1'b0;
      pend_d  = 1'b1;
    end

    uo_out_d = '0;
    if (IRQ_OUT) uo_out_d = {5'b0, done_d, state_d == ST_RUN, 1'b0};
  end

  // State registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_q      <= '0;
      b_q      <= '0;
      op_q     <= '0;
      rsel_q   <= '0;
      state_q  <= ST_IDLE;
      pend_q   <= 1'b0;
      done_q   <= 1'b0;
      dz_q     <= 1'b0;
      ill_q    <= 1'b0;
      carry_q  <= 1'b0;
      result_q <= '0;
      uo_out_q <= '0;
    end else begin
      a_q      <= a_d;
      b_q      <= b_d;
      op_q     <= op_d;
      rsel_q   <= rsel_d;
      state_q  <= state_d;
      pend_q   <= pend_d;
      done_q   <= done_d;
      dz_q     <= dz_d;
      ill_q    <= ill_d;
      carry_q  <= carry_d;
      result_q <= result_d;
      uo_out_q <= uo_out_d;
    end
  end

  assign uo_out = uo_out_q;

  // Read mux; zero-extension makes out-of-range operand/result bytes read 0
  always_comb begin
    logic [31:0] a_r, b_r;
    logic [63:0] res_r;
    a_r      = 32'(a_q);
    b_r      = 32'(b_q);
    res_r    = 64'(result_q);
    data_out = '0;
    if (address[3] == 1'b0) begin
      data_out = address[2] ? b_r[{address[1:0], 3'b000} +: 8]
                            : a_r[{address[1:0], 3'b000} +: 8];
    end else begin
      case (address)
        ADDR_OP:    data_out = {4'b0, op_q};
        ADDR_CSR:   data_out = {3'b0, carry_q, ill_q, dz_q, done_q, state_q == ST_RUN};
        ADDR_RSEL:  data_out = {5'b0, rsel_q};
        ADDR_RDATA: data_out = res_r[{rsel_q, 3'b000} +: 8];
        default:    data_out = '0;
      endcase
    end
  end

endmodule

// File: tb/tb_param_math_accel.sv
module tb_param_math_accel;
  import param_math_accel_pkg::*;

  localparam int unsigned W = 16;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [7:0] ui_in;
  logic [7:0] uo_out;
  logic [3:0] address;
  logic       data_write;
  logic [7:0] data_in;
  logic [7:0] data_out;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  param_math_accel #(.W(W), .IRQ_OUT(1'b1)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .ui_in      (ui_in),
    .uo_out     (uo_out),
    .address    (address),
    .data_write (data_write),
    .data_in    (data_in),
    .data_out   (data_out)
  );

  typedef struct {
    logic [15:0] a;
    logic [15:0] b;
    logic [3:0]  op;
    logic [31:0] res;
    logic [2:0]  cid;   // {carry, illegal, dz}
  } vec_t;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // One bus write; the write is sampled on the posedge in the middle
  task automatic wr(input logic [3:0] ad, input logic [7:0] d);
    @(negedge clk);
    address    = ad;
    data_in    = d;
    data_write = 1'b1;
    @(negedge clk);
    data_write = 1'b0;
  endtask

  task automatic rd(input logic [3:0] ad, output logic [7:0] d);
    address = ad;
    #1;
    d = data_out;
  endtask

  task automatic read_result(output logic [31:0] r);
    logic [7:0] byt;
    r = '0;
    for (int i = 0; i < 4; i++) begin
      wr(ADDR_RSEL, 8'(i));
      rd(ADDR_RDATA, byt);
      r[i*8 +: 8] = byt;
    end
  endtask

  task automatic load_ops(input logic [15:0] a, input logic [15:0] b, input logic [3:0] op);
    wr(4'h0, a[7:0]);
    wr(4'h1, a[15:8]);
    wr(4'h4, b[7:0]);
    wr(4'h5, b[15:8]);
    wr(ADDR_OP, {4'b0, op});
  endtask

  // Poll CSR until done, counting cycles after the accepting edge
  task automatic wait_done(inout int lat, inout int busy_cnt, output logic [7:0] csr);
    rd(ADDR_CSR, csr);
    while (!csr[CSR_DONE] && lat < 100) begin
      @(negedge clk);
      lat++;
      rd(ADDR_CSR, csr);
      if (csr[CSR_BUSY]) busy_cnt++;
    end
  endtask

  task automatic run_op(input logic [15:0] a, input logic [15:0] b, input logic [3:0] op,
                        output logic [31:0] res, output logic [7:0] csr,
                        output int lat, output int busy_cnt, output logic [7:0] uo);
    load_ops(a, b, op);
    wr(ADDR_CSR, 8'h01);
    lat = 0;
    busy_cnt = 0;
    wait_done(lat, busy_cnt, csr);
    uo = uo_out;
    read_result(res);
  endtask

  // Reference: spec arithmetic on wide integers
  function automatic void model(input logic [15:0] a, input logic [15:0] b, input logic [3:0] op,
                                output logic [31:0] res, output logic [2:0] cid);
    longint unsigned x, y, m;
    x = 64'(a); y = 64'(b); m = 64'hFFFF;
    res = '0;
    cid = '0;
    case (op)
      4'd0: begin res = 32'(x + y); cid[2] = (x + y) > m; end
      4'd1: begin res = 32'((x - y) & m); cid[2] = x < y; end
      4'd2: res = 32'(x * y);
      4'd3: if (y == 0) begin res = 32'((x << 16) | m); cid[0] = 1'b1; end
            else res = 32'(((x % y) << 16) | (x / y));
      4'd4: res = 32'(x & y);
      4'd5: res = 32'(x | y);
      4'd6: res = 32'(x ^ y);
      4'd7: res = 32'((x < y) ? x : y);
      4'd8: res = 32'((x < y) ? y : x);
      4'd9: res = 32'(x << (y % 16));
      default: cid[1] = 1'b1;
    endcase
  endfunction

  function automatic int exp_lat(input logic [3:0] op, input logic [15:0] b);
    return (op == 4'd2 || (op == 4'd3 && b != 0)) ? 17 : 1;
  endfunction

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    vec_t        vecs[16];
    logic [31:0] res, exp_res;
    logic [7:0]  csr, uo, d;
    logic [2:0]  cid;
    logic [15:0] ra, rb;
    logic [3:0]  rop;
    int          lat, bc;

    vecs[0]  = '{16'h1234, 16'h0100, 4'd2,  32'h00123400, 3'b000};
    vecs[1]  = '{16'h03E8, 16'h0007, 4'd3,  32'h0006008E, 3'b000};
    vecs[2]  = '{16'h00AB, 16'h0000, 4'd3,  32'h00ABFFFF, 3'b001};
    vecs[3]  = '{16'h0005, 16'h0007, 4'd1,  32'h0000FFFE, 3'b100};
    vecs[4]  = '{16'h0005, 16'h0007, 4'd12, 32'h00000000, 3'b010};
    vecs[5]  = '{16'hFFFF, 16'h0001, 4'd0,  32'h00010000, 3'b100};
    vecs[6]  = '{16'hFFFF, 16'hFFFF, 4'd2,  32'hFFFE0001, 3'b000};
    vecs[7]  = '{16'h00F0, 16'h0F0F, 4'd4,  32'h00000000, 3'b000};
    vecs[8]  = '{16'h00F0, 16'h0F0F, 4'd5,  32'h00000FFF, 3'b000};
    vecs[9]  = '{16'h00F0, 16'h0F0F, 4'd6,  32'h00000FFF, 3'b000};
    vecs[10] = '{16'h1234, 16'h0005, 4'd7,  32'h00000005, 3'b000};
    vecs[11] = '{16'h1234, 16'h0005, 4'd8,  32'h00001234, 3'b000};
    vecs[12] = '{16'h8001, 16'h0011, 4'd9,  32'h00010002, 3'b000};
    vecs[13] = '{16'hFFFF, 16'h0001, 4'd3,  32'h0000FFFF, 3'b000};
    vecs[14] = '{16'h0003, 16'h0005, 4'd0,  32'h00000008, 3'b000};
    vecs[15] = '{16'hFFFF, 16'h000F, 4'd9,  32'h7FFF8000, 3'b000};

    rst_n = 1'b0; ui_in = '0; address = '0; data_write = 1'b0; data_in = '0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;

    // Reset state
    rd(ADDR_CSR, d);   check("reset_csr", 64'(d), 64'h00);
    check("reset_uo", 64'(uo_out), 64'h00);
    rd(ADDR_RDATA, d); check("reset_rdata", 64'(d), 64'h00);
    rd(4'h0, d);       check("reset_a0", 64'(d), 64'h00);
    rd(ADDR_OP, d);    check("reset_op", 64'(d), 64'h00);

    // Byte-range rules
    wr(4'h2, 8'h55); rd(4'h2, d); check("a2_ignored", 64'(d), 64'h00);
    wr(4'h0, 8'hA5); rd(4'h0, d); check("a0_write", 64'(d), 64'hA5);
    rd(4'hC, d); check("addr_c_zero", 64'(d), 64'h00);

    // Directed table
    foreach (vecs[i]) begin
      run_op(vecs[i].a, vecs[i].b, vecs[i].op, res, csr, lat, bc, uo);
      check($sformatf("vec%0d_res", i), 64'(res), 64'(vecs[i].res));
      check($sformatf("vec%0d_csr", i), 64'(csr), 64'({3'b000, vecs[i].cid, 2'b10}));
      check($sformatf("vec%0d_lat", i), 64'(lat), 64'(exp_lat(vecs[i].op, vecs[i].b)));
      check($sformatf("vec%0d_busy", i), 64'(bc), 64'(exp_lat(vecs[i].op, vecs[i].b) == 17 ? 16 : 0));
      check($sformatf("vec%0d_uo", i), 64'(uo), 64'h04);
    end

    // Result bytes above 2W read zero (last result nonzero)
    wr(ADDR_RSEL, 8'h04); rd(ADDR_RDATA, d); check("rsel4_zero", 64'(d), 64'h00);
    wr(ADDR_RSEL, 8'h07); rd(ADDR_RDATA, d); check("rsel7_zero", 64'(d), 64'h00);

    // CLEAR when idle clears flags but keeps result
    run_op(16'd5, 16'd7, 4'd1, res, csr, lat, bc, uo);
    wr(ADDR_CSR, 8'h02);
    rd(ADDR_CSR, d); check("clear_idle_csr", 64'(d), 64'h00);
    read_result(res); check("clear_idle_res", 64'(res), 64'h0000FFFE);

    // ABORT (with START) while busy
    run_op(16'd3, 16'd5, 4'd0, res, csr, lat, bc, uo);
    load_ops(16'h1234, 16'h0100, 4'd2);
    wr(ADDR_CSR, 8'h01);
    repeat (5) @(negedge clk);
    rd(ADDR_CSR, d); check("abort_pre_busy", 64'(d), 64'h01);
    wr(ADDR_CSR, 8'h05);
    rd(ADDR_CSR, d); check("abort_csr", 64'(d), 64'h00);
    check("abort_uo", 64'(uo_out), 64'h00);
    repeat (20) @(negedge clk);
    rd(ADDR_CSR, d); check("abort_later_csr", 64'(d), 64'h00);
    read_result(res); check("abort_res_kept", 64'(res), 64'h00000008);

    // START ignored mid-run; A rewrite does not affect product
    load_ops(16'd3, 16'd5, 4'd2);
    wr(ADDR_CSR, 8'h01);
    lat = 0; bc = 0;
    repeat (3) begin @(negedge clk); lat++; end
    wr(4'h0, 8'h77); lat += 2;
    wr(ADDR_CSR, 8'h01); lat += 2;
    rd(ADDR_CSR, d); check("midrun_busy", 64'(d), 64'h01);
    check("midrun_uo", 64'(uo_out), 64'h02);
    wait_done(lat, bc, csr);
    check("midrun_lat", 64'(lat), 64'd17);
    check("midrun_csr", 64'(csr), 64'h02);
    read_result(res); check("midrun_res", 64'(res), 64'd15);

    // CLEAR while busy: operation still completes
    load_ops(16'd9, 16'd9, 4'd2);
    wr(ADDR_CSR, 8'h01);
    lat = 0; bc = 0;
    repeat (3) begin @(negedge clk); lat++; end
    wr(ADDR_CSR, 8'h02); lat += 2;
    wait_done(lat, bc, csr);
    check("clear_busy_lat", 64'(lat), 64'd17);
    read_result(res); check("clear_busy_res", 64'(res), 64'd81);

    // Randomized vs model
    for (int n = 0; n < 120; n++) begin
      ra  = 16'($urandom);
      rb  = ($urandom_range(0, 5) == 0) ? 16'h0 : 16'($urandom);
      rop = 4'($urandom_range(0, 15));
      model(ra, rb, rop, exp_res, cid);
      run_op(ra, rb, rop, res, csr, lat, bc, uo);
      check($sformatf("rnd%0d_op%0d_res", n, rop), 64'(res), 64'(exp_res));
      check($sformatf("rnd%0d_op%0d_csr", n, rop), 64'(csr), 64'({3'b000, cid, 2'b10}));
      check($sformatf("rnd%0d_op%0d_lat", n, rop), 64'(lat), 64'(exp_lat(rop, rb)));
    end

    // Asynchronous reset mid-run
    wr(ADDR_RSEL, 8'h01);
    load_ops(16'h1234, 16'h0100, 4'd2);
    wr(ADDR_CSR, 8'h01);
    repeat (3) @(negedge clk);
    #2 rst_n = 1'b0;
    rd(ADDR_CSR, d);   check("arst_csr", 64'(d), 64'h00);
    check("arst_uo", 64'(uo_out), 64'h00);
    rd(ADDR_RDATA, d); check("arst_rdata", 64'(d), 64'h00);
    rd(ADDR_RSEL, d);  check("arst_rsel", 64'(d), 64'h00);
    rd(4'h1, d);       check("arst_a1", 64'(d), 64'h00);
    @(negedge clk);
    rst_n = 1'b1;
    run_op(16'd20, 16'd22, 4'd0, res, csr, lat, bc, uo);
    check("post_rst_res", 64'(res), 64'd42);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
